// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------------------------
// uart_tx -- UART transmitter, one byte per frame, LSB first (8N1 by default).
//
// Serialises a byte accepted on the valid/ready handshake onto o_tx_serial. Bit timing matches
// uart_rx (CLKS_PER_BIT clocks per bit), so a tx->rx loopback is bit-exact.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : a parity bit (even, or odd when PARITY_ODD=1) follows data bit 7.
//   undefined : no parity state or logic; PARITY_ODD is not used by the datapath.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_tx_dv      byte valid; accepted on an edge where i_tx_dv && o_tx_ready
//   i_tx_byte    byte to send, sampled only at acceptance
//   o_tx_ready   high only while idle
//   o_tx_serial  serial line, idles high
//   o_tx_active  high from the start bit through the last stop cycle
//   o_tx_done    one-cycle pulse when a frame completes
// ---------------------------------------------------------------------------------------------
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tx_dv,
   input  logic [7:0] i_tx_byte,
   output logic       o_tx_ready,
   output logic       o_tx_serial,
   output logic       o_tx_active,
   output logic       o_tx_done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   // Elaboration-time parameter legality checks.
   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx: CLKS_PER_BIT must be >= 2");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD > 1) begin : g_bad_parity
      $error("uart_tx: PARITY_ODD must be 0 or 1");
   end

   logic [2:0]       state_q;
   logic [CNT_W-1:0] cnt_q;     // clocks elapsed within the current bit
   logic [2:0]       idx_q;     // data bit index; reused as stop-bit index in S_STOP
   logic [7:0]       data_q;    // byte latched at acceptance, never touched mid-frame
   logic             ready_q;
   logic             serial_q;
   logic             active_q;
   logic             done_q;
   logic             bit_end;

`ifdef UART_TX_PARITY_EN
   logic             parity_bit;
   assign parity_bit = (^data_q) ^ PARITY_ODD[0];
`endif

   assign bit_end = (cnt_q == CNT_LAST);

   // Outputs are loaded together with the state they belong to, so the line changes on the
   // same edge the FSM moves; an accepted byte drives the start bit from the acceptance edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         ready_q  <= 1'b1;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_tx_dv) begin
                  data_q   <= i_tx_byte;
                  state_q  <= S_START;
                  cnt_q    <= '0;
                  idx_q    <= '0;
                  serial_q <= 1'b0;
                  ready_q  <= 1'b0;
                  active_q <= 1'b1;
               end
            end
            S_START: begin
               if (bit_end) begin
                  cnt_q    <= '0;
                  idx_q    <= '0;
                  state_q  <= S_DATA;
                  serial_q <= data_q[0];
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (idx_q == 3'd7) begin
                     idx_q    <= '0;
`ifdef UART_TX_PARITY_EN
                     state_q  <= S_PARITY;
                     serial_q <= parity_bit;
`else
                     state_q  <= S_STOP;
                     serial_q <= 1'b1;
`endif
                  end else begin
                     idx_q    <= idx_q + 3'd1;
                     serial_q <= data_q[idx_q + 3'd1];
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  cnt_q    <= '0;
                  idx_q    <= '0;
                  state_q  <= S_STOP;
                  serial_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (idx_q == STOP_LAST) begin
                     idx_q    <= '0;
                     state_q  <= S_IDLE;
                     ready_q  <= 1'b1;
                     active_q <= 1'b0;
                     done_q   <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q  <= S_IDLE;
               cnt_q    <= '0;
               idx_q    <= '0;
               ready_q  <= 1'b1;
               serial_q <= 1'b1;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_tx_ready  = ready_q;
   assign o_tx_serial = serial_q;
   assign o_tx_active = active_q;
   assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, single frame, back-to-back, two stop bits, busy-ignore,
// reset mid-frame. Cycle n of a frame is the interval following the n-th edge after acceptance
// (acceptance edge = cycle 1 start); outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx;

   localparam int CPB         = 8;
   localparam int STOP_BITS   = 1;
   localparam int PARITY_ODD  = 0;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME  = (10 + PAR + STOP_BITS - 1) * CPB;
   localparam int FRAME2 = (10 + PAR + 2 - 1) * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_dv, tx_dv2;
   logic [7:0] tx_byte, tx_byte2;
   logic       tx_ready, tx_serial, tx_active, tx_done;
   logic       tx_ready2, tx_serial2, tx_active2, tx_done2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOP_BITS), .PARITY_ODD(PARITY_ODD)) dut (
      .i_clk(clk), .i_rst(rst), .i_tx_dv(tx_dv), .i_tx_byte(tx_byte),
      .o_tx_ready(tx_ready), .o_tx_serial(tx_serial), .o_tx_active(tx_active),
      .o_tx_done(tx_done)
   );

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(PARITY_ODD)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_tx_dv(tx_dv2), .i_tx_byte(tx_byte2),
      .o_tx_ready(tx_ready2), .o_tx_serial(tx_serial2), .o_tx_active(tx_active2),
      .o_tx_done(tx_done2)
   );

   // Expected line level in frame cycle c (1-based) for byte b.
   function automatic logic exp_line(input logic [7:0] b, input int c);
      int slot;
      slot = (c - 1) / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      if (PAR == 1 && slot == 9) return (^b) ^ PARITY_ODD[0];
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; tx_dv = 1'b0; tx_byte = 8'h00; tx_dv2 = 1'b0; tx_byte2 = 8'h00;
      repeat (4) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 21; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({tx_serial, tx_ready, tx_active, tx_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got srl/rdy/act/done=%b want 1100", i,
                     {tx_serial, tx_ready, tx_active, tx_done});
         end
      end
   endtask

   // Sends byte b and checks every cycle of the frame; optionally pulses dv with inj_byte
   // during frame cycle inj_cyc (busy, must be ignored).
   task automatic run_frame(input logic [7:0] b, input int inj_cyc, input logic [7:0] inj_byte);
      logic [7:0] dec;
      dec = 8'h00;
      @(negedge clk); tx_byte = b; tx_dv = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= FRAME + 1; c++) begin
         checks++;
         if (tx_serial !== exp_line(b, c)) begin
            errors++;
            $display("FAIL frame_line byte=%h cyc=%0d got %b want %b", b, c, tx_serial,
                     exp_line(b, c));
         end
         checks++;
         if ({tx_done, tx_ready, tx_active} !== {c == FRAME + 1, c == FRAME + 1, c <= FRAME})
         begin
            errors++;
            $display("FAIL frame_flags byte=%h cyc=%0d got done/rdy/act=%b want %b", b, c,
                     {tx_done, tx_ready, tx_active},
                     {c == FRAME + 1, c == FRAME + 1, c <= FRAME});
         end
         if (c > CPB && c <= 9 * CPB && ((c - 1) % CPB) == CPB / 2) dec[(c - 1) / CPB - 1] = tx_serial;
         @(negedge clk);
         tx_dv   = (c == inj_cyc);
         tx_byte = (c == inj_cyc) ? inj_byte : ~b;
         @(posedge clk); #1;
      end
      checks++;
      if (dec !== b) begin
         errors++;
         $display("FAIL frame_decode got %h want %h", dec, b);
      end
      for (int i = 0; i < 2 * CPB; i++) begin
         checks++;
         if ({tx_serial, tx_ready, tx_active, tx_done} !== 4'b1100) begin
            errors++;
            $display("FAIL frame_after byte=%h cyc=%0d got srl/rdy/act/done=%b want 1100", b,
                     i, {tx_serial, tx_ready, tx_active, tx_done});
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_frame();
      run_frame(8'h59, 0, 8'h00);
   endtask

   task automatic test_back_to_back();
      @(negedge clk); tx_byte = 8'h00; tx_dv = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= FRAME + 1; c++) begin
         checks++;
         if ({tx_serial, tx_done} !== {exp_line(8'h00, c), c == FRAME + 1}) begin
            errors++;
            $display("FAIL b2b_first cyc=%0d got srl/done=%b want %b", c, {tx_serial, tx_done},
                     {exp_line(8'h00, c), c == FRAME + 1});
         end
         @(negedge clk); tx_byte = 8'hFF;
         @(posedge clk); #1;
      end
      for (int c = 1; c <= FRAME + 1; c++) begin
         checks++;
         if ({tx_serial, tx_done} !== {exp_line(8'hFF, c), c == FRAME + 1}) begin
            errors++;
            $display("FAIL b2b_second cyc=%0d got srl/done=%b want %b", c, {tx_serial, tx_done},
                     {exp_line(8'hFF, c), c == FRAME + 1});
         end
         @(negedge clk); tx_dv = 1'b0;
         @(posedge clk); #1;
      end
      checks++;
      if ({tx_serial, tx_ready} !== 2'b11) begin
         errors++;
         $display("FAIL b2b_idle got srl/rdy=%b want 11", {tx_serial, tx_ready});
      end
   endtask

   task automatic test_stop2();
      @(negedge clk); tx_byte2 = 8'h00; tx_dv2 = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= FRAME2 + 2; c++) begin
         // cycle FRAME2+2 is cycle 1 of the next frame: start bit, period FRAME2+1
         checks++;
         if ({tx_serial2, tx_done2} !==
             {(c == FRAME2 + 2) ? 1'b0 : exp_line(8'h00, c), c == FRAME2 + 1}) begin
            errors++;
            $display("FAIL stop2 cyc=%0d got srl/done=%b want %b", c, {tx_serial2, tx_done2},
                     {(c == FRAME2 + 2) ? 1'b0 : exp_line(8'h00, c), c == FRAME2 + 1});
         end
         @(posedge clk); #1;
      end
      @(negedge clk); tx_dv2 = 1'b0;
      repeat (FRAME2 + 4) @(posedge clk);
      #1;
      checks++;
      if ({tx_serial2, tx_ready2, tx_active2} !== 3'b110) begin
         errors++;
         $display("FAIL stop2_idle got srl/rdy/act=%b want 110", {tx_serial2, tx_ready2,
                  tx_active2});
      end
   endtask

   task automatic test_busy_ignore();
      run_frame(8'h59, 3 * CPB + CPB + 4, 8'hAA);
   endtask

   task automatic test_reset_mid();
      @(negedge clk); tx_byte = 8'hC3; tx_dv = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 5 * CPB + 4; c++) begin
         checks++;
         if (tx_serial !== exp_line(8'hC3, c)) begin
            errors++;
            $display("FAIL rstmid_line cyc=%0d got %b want %b", c, tx_serial,
                     exp_line(8'hC3, c));
         end
         @(negedge clk); tx_dv = 1'b0;
         if (c == 5 * CPB + 4) rst = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if ({tx_serial, tx_ready, tx_active, tx_done} !== 4'b1100) begin
         errors++;
         $display("FAIL rstmid_state got srl/rdy/act/done=%b want 1100",
                  {tx_serial, tx_ready, tx_active, tx_done});
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 2 * CPB; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({tx_serial, tx_ready, tx_done} !== 3'b110) begin
            errors++;
            $display("FAIL rstmid_after cyc=%0d got srl/rdy/done=%b want 110", i,
                     {tx_serial, tx_ready, tx_done});
         end
      end
      run_frame(8'h3C, 0, 8'h00);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_stop2();
      test_busy_ignore();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
